seq_detector_param: RTL and testbench

Parametrised serial pattern detector. It is the successor of the fixed-pattern seq_detector.
- Pattern width, default pattern, overlap mode and counter width are generics.
- The pattern can be reloaded at runtime.
- Adds a serial-input enable and a saturating match counter.
- Sits behind a serial input line; z drives downstream event logic, and the counter feeds status readback.

---
 rtl/seq_det_pkg.sv | 6 +
 rtl/seq_detector_param_sat_counter.sv | 38 +++
 rtl/seq_detector_param.sv | 84 ++++++++
 tb/tb_seq_detector_param.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector.
package seq_det_pkg;
  localparam bit OVL_ON    = 1'b1;
  localparam bit OVL_OFF   = 1'b0;
  localparam int MAX_PAT_W = 16;
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // sat tracks the registered count, so it is derived from the next value
    sat_d = &cnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign count_o = cnt_q;
  assign sat_o   = sat_q;
endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern, sample enable,
// optional overlap and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = OVL_ON,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic [PAT_W-1:0] pat
);
  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  if (PAT_W < 2 || PAT_W > MAX_PAT_W) begin : g_bad_pat_w
    $error("seq_detector_param: PAT_W must be in 2..16");
  end

  logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
  logic [FILL_W-1:0] fill_q, fill_d, fill_n;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              z_q, z_d;
  logic              hit;

  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], x};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    // fill gating keeps a zero-filled history from matching an all-zero pattern
    hit    = en && !load && (fill_n == FILL_FULL) && (hist_n == pat_q);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    z_d    = 1'b0;
    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_n;
      fill_d = (hit && !OVERLAP) ? '0 : fill_n;
      z_d    = hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      z_q    <= z_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (hit),
    .clr_i  (clr_cnt),
    .count_o(match_cnt),
    .sat_o  (cnt_sat)
  );

  assign z   = z_q;
  assign pat = pat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap, no-overlap and a 2-bit/2-bit-counter instance.
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, x = 1'b0, load = 1'b0, clr_cnt = 1'b0;
  logic [3:0] pat_in = 4'h0;
  logic       en2 = 1'b0, x2 = 1'b0;
  logic [1:0] pat_in2 = 2'b11;

  logic       z0, z1, z2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       sat0, sat1, sat2;
  logic [3:0] pat0, pat1;
  logic [1:0] pat2;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic z0;
    logic z1;
    logic z2;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .z(z0), .match_cnt(cnt0), .cnt_sat(sat0), .pat(pat0));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .z(z1), .match_cnt(cnt1), .cnt_sat(sat1), .pat(pat1));

  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .en(en2), .x(x2), .load(load), .pat_in(pat_in2),
    .clr_cnt(clr_cnt), .z(z2), .match_cnt(cnt2), .cnt_sat(sat2), .pat(pat2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic xi, input logic eni, input logic xi2, input logic eni2,
                      input logic ld, input logic [3:0] pi, input logic clr,
                      input logic ez0, input logic ez1, input logic ez2);
    exp_t e;
    x = xi; en = eni; x2 = xi2; en2 = eni2; load = ld; pat_in = pi; clr_cnt = clr;
    e.z0 = ez0; e.z1 = ez1; e.z2 = ez2;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("z_ovl", 32'(z0), 32'(e.z0));
    chk("z_noovl", 32'(z1), 32'(e.z1));
    chk("z_w2", 32'(z2), 32'(e.z2));
  endtask

  // Async reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    en = 1'b0; en2 = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_z0", 32'(z0), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_pat0", 32'(pat0), 32'hD);
    chk("rst_sat0", 32'(sat0), 32'd0);
    #2 reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("init_z0", 32'(z0), 32'd0);
    chk("init_z2", 32'(z2), 32'd0);
    chk("init_cnt0", 32'(cnt0), 32'd0);
    chk("init_sat2", 32'(sat2), 32'd0);
    chk("init_pat0", 32'(pat0), 32'hD);
    chk("init_pat2", 32'(pat2), 32'h3);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // 1101101: overlap matches at bits 4 and 7, no-overlap only at bit 4
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    chk("t1_cnt_ovl", 32'(cnt0), 32'd2);
    chk("t1_cnt_noovl", 32'(cnt1), 32'd1);
    chk("t1_sat1", 32'(sat1), 32'd0);

    // bubbles between partial match bits
    do_reset();
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    chk("t3_cnt0", 32'(cnt0), 32'd1);

    // runtime load wins over a completing 1101 match
    do_reset();
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 4'b0110, 0, 0, 0, 0);
    chk("t4_pat0", 32'(pat0), 32'h6);
    chk("t4_pat1", 32'(pat1), 32'h6);
    chk("t4_cnt0", 32'(cnt0), 32'd0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    chk("t4_cnt1", 32'(cnt1), 32'd1);

    // 2-bit counter saturation, then clear against a coincident hit
    do_reset();
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    chk("t5_cnt_a", 32'(cnt2), 32'd0);
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
    chk("t5_cnt_b", 32'(cnt2), 32'd1);
    chk("t5_sat_b", 32'(sat2), 32'd0);
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
    chk("t5_cnt_c", 32'(cnt2), 32'd2);
    chk("t5_sat_c", 32'(sat2), 32'd0);
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
    chk("t5_cnt_d", 32'(cnt2), 32'd3);
    chk("t5_sat_d", 32'(sat2), 32'd1);
    step(0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 1);
    chk("t5_cnt_e", 32'(cnt2), 32'd3);
    chk("t5_sat_e", 32'(sat2), 32'd1);
    step(0, 0, 1, 1, 0, 4'h0, 1, 0, 0, 1);
    chk("t5_clr_cnt", 32'(cnt2), 32'd0);
    chk("t5_clr_sat", 32'(sat2), 32'd0);

    // async reset right after a match pulse, then refill and clear on a hit
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    chk("t6_cnt_pre", 32'(cnt0), 32'd1);
    do_reset();
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 4'h0, 1, 1, 1, 0);
    chk("t6_clr_cnt0", 32'(cnt0), 32'd0);
    chk("t6_clr_cnt1", 32'(cnt1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
